// File: rtl/rf_ctrl_pkg.sv
// Shared constants for the register-file instruction sequencer:
// opcode/op codes, FSM state encodings, vsel encodings and instruction classes.
package rf_ctrl_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_WRITE_IMM = 3'd2;
    localparam logic [2:0] S_GET_A     = 3'd3;
    localparam logic [2:0] S_GET_B     = 3'd4;
    localparam logic [2:0] S_ALU       = 3'd5;
    localparam logic [2:0] S_WRITE_REG = 3'd6;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    localparam logic [2:0] CLS_ILL  = 3'd0;
    localparam logic [2:0] CLS_MOVI = 3'd1;
    localparam logic [2:0] CLS_MOVR = 3'd2;
    localparam logic [2:0] CLS_ADD  = 3'd3;
    localparam logic [2:0] CLS_CMP  = 3'd4;
    localparam logic [2:0] CLS_AND  = 3'd5;
    localparam logic [2:0] CLS_MVN  = 3'd6;

endpackage

// File: rtl/rf_controller_instr_dec.sv
// Combinational instruction decoder: splits the latched instruction into
// register fields, shift, ALU op, sign-extended immediates and a class code.
// Ports: ir_i (instruction), rn_o/rd_o/rm_o, shift_o, aluop_o,
//        sximm8_o, sximm5_o, cls_o (CLS_ILL for anything unsupported).
module instr_dec
    import rf_ctrl_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [2:0]  rn_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rm_o,
    output logic [1:0]  shift_o,
    output logic [1:0]  aluop_o,
    output logic [15:0] sximm8_o,
    output logic [15:0] sximm5_o,
    output logic [2:0]  cls_o
);

    logic [2:0] opcode;
    logic [1:0] op;

    assign opcode   = ir_i[15:13];
    assign op       = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign shift_o  = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
    assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

    // MOV reg shares op 00 with ADD, so it already maps to the pass-through op.
    assign aluop_o  = (opcode == OPC_ALU) ? op : 2'b00;

    always_comb begin
        cls_o = CLS_ILL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOVI)
                cls_o = CLS_MOVI;
            else if (op == OP_MOVR)
                cls_o = CLS_MOVR;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls_o = CLS_ADD;
                OP_CMP:  cls_o = CLS_CMP;
                OP_AND:  cls_o = CLS_AND;
                default: cls_o = CLS_MVN;
            endcase
        end
    end

endmodule

// File: rtl/rf_controller.sv
// Instruction sequencer driving the 8x16 register file and datapath strobes,
// one micro-step per clock. Ports: clk, reset (async, active-high), s/in
// (start + instruction), w (idle), readnum/writenum/write (register file),
// loada/loadb/loadc/loads, asel/bsel/vsel, shift/ALUop, sximm8/sximm5.
module rf_controller
    import rf_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    logic [15:0] ir_q, ir_d;
    logic [2:0]  state_q, state_d;

    logic [2:0]  rn, rd, rm, cls;

    instr_dec u_dec (
        .ir_i     (ir_q),
        .rn_o     (rn),
        .rd_o     (rd),
        .rm_o     (rm),
        .shift_o  (shift),
        .aluop_o  (ALUop),
        .sximm8_o (sximm8),
        .sximm5_o (sximm5),
        .cls_o    (cls)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d = S_DECODE;
                    ir_d    = in;
                end
            end
            S_DECODE: begin
                case (cls)
                    CLS_MOVI:          state_d = S_WRITE_IMM;
                    CLS_MOVR, CLS_MVN: state_d = S_GET_B;
                    CLS_ADD, CLS_CMP,
                    CLS_AND:           state_d = S_GET_A;
                    default:           state_d = S_WAIT;
                endcase
            end
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = (cls == CLS_CMP) ? S_WAIT : S_WRITE_REG;
            S_WRITE_IMM: state_d = S_WAIT;
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Moore decode: depends only on state_q and ir_q, never on s or in.
    always_comb begin
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        vsel     = VSEL_C;
        case (state_q)
            S_WAIT: w = 1'b1;
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_ALU: begin
                loadc = (cls != CLS_CMP);
                loads = (cls == CLS_CMP);
                asel  = (cls == CLS_MOVR);
            end
            S_WRITE_REG: begin
                writenum = rd;
                write    = 1'b1;
                vsel     = VSEL_C;
            end
            S_WRITE_IMM: begin
                writenum = rn;
                write    = 1'b1;
                vsel     = VSEL_IMM8;
            end
            default: ;
        endcase
    end

    // Immediate B operand is reserved for later instructions.
    assign bsel = 1'b0;

endmodule

// File: doc/rf_controller.md
# rf_controller

Instruction sequencer that acts as the initiator side of the 8×16 register file: it accepts one 16-bit instruction per start pulse, then drives the register file's `readnum`, `writenum` and `write` together with the datapath load and select strobes, one micro-step per clock. It sits between instruction fetch and the datapath/register file, and it is the only agent that issues register reads and writes.

## Interface
- No parameters; instruction and data width fixed at 16.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `s` in 1: start; sampled only in WAIT.
- `in` in 16: instruction; captured when accepted.
- `w` out 1: idle/ready, high only in WAIT.
- `readnum` out 3: register file read index.
- `writenum` out 3: register file write index.
- `write` out 1: register file write enable.
- `loada`, `loadb`, `loadc`, `loads` out 1 each: load strobes for datapath regs A, B, C and status.
- `asel`, `bsel` out 1 each: 1 forces the ALU A operand to 0, or selects `sximm5` as the B operand.
- `vsel` out 2: write-back source: 00 = C, 10 = `sximm8`; 01 and 11 are never driven.
- `shift` out 2, `ALUop` out 2: from the latched instruction.
- `sximm8`, `sximm5` out 16: sign-extended `ir[7:0]` and `ir[4:0]`.

## Operation
- Fields of latched `ir`: opcode `[15:13]`, op `[12:11]`, Rn `[10:8]`, Rd `[7:5]`, shift `[4:3]`, Rm `[2:0]`.
- Supported instructions:
  - MOV imm (110/10): Rn ← sximm8.
  - MOV reg (110/00): Rd ← sh(Rm).
  - ADD (101/00): Rd ← Rn + sh(Rm).
  - CMP (101/01): status ← Rn − sh(Rm).
  - AND (101/10): Rd ← Rn & sh(Rm).
  - MVN (101/11): Rd ← ~sh(Rm).
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
- Transitions:
  - WAIT: goes to DECODE when `s` is 1, latching `ir` ← `in`.
  - DECODE → WRITE_IMM for MOV imm.
  - DECODE → GET_B for MOV reg and MVN.
  - DECODE → GET_A for ADD, CMP and AND.
  - DECODE → WAIT for any other opcode/op: no write, no load.
  - GET_A → GET_B → ALU.
  - ALU → WAIT for CMP; ALU → WRITE_REG otherwise.
  - WRITE_IMM → WAIT and WRITE_REG → WAIT.
- Moore outputs per state (unlisted strobes 0; unlisted indices 0):
  - GET_A: `readnum`=Rn, `loada`=1.
  - GET_B: `readnum`=Rm, `loadb`=1.
  - ALU: `loadc`=1 except CMP; `loads`=1 for CMP only; `asel`=1 for MOV reg.
  - WRITE_REG: `writenum`=Rd, `write`=1, `vsel`=00.
  - WRITE_IMM: `writenum`=Rn, `write`=1, `vsel`=10.
- `bsel` is always 0, reserved for the immediate-offset instructions that come next.
- ALUop mapping:
  - MOV reg and ADD drive 00.
  - All 101 instructions otherwise drive op.
- `shift`, `sximm8` and `sximm5` track `ir` continuously.

## Timing
- Reset: state WAIT, `ir`=0, `w`=1, every strobe 0, `readnum`=`writenum`=0, `vsel`=00. Reset during any state aborts the instruction; no further write or load occurs.
- Latency in cycles after the accepting edge, ending in WAIT:
  - MOV imm: 2.
  - MOV reg and MVN: 4.
  - CMP: 4.
  - ADD and AND: 5.
  - Illegal: 1.
- `s` is ignored outside WAIT; `in` is don't-care after capture.
- If `s` is high on the same edge that enters WAIT, nothing is accepted. Acceptance occurs on the next edge if `s` is still high, so back-to-back instructions have a one-cycle WAIT gap (`w`=1 for at least one cycle).
- Write-back: `write` is high for exactly one cycle per writing instruction. The register file captures on the edge ending WRITE_REG or WRITE_IMM.
- Outputs are decoded from state and `ir` only, with no combinational path from `s` or `in`.

## Structure
- Shared package `rf_ctrl_pkg` holds:
  - opcode/op constants;
  - the state enum;
  - `vsel` encodings (VSEL_C = 00, VSEL_IMM8 = 10).
- Sub-module `instr_dec` is combinational. It maps `ir` to the fields, `sximm8`, `sximm5`, and a legal/class indication.
- `rf_controller` holds `ir`, the state register, next-state logic and output decode.

## Test plan
- MOV imm: `in`=16'hD0F0 (MOV R0,#−16), `s` pulse → `write`=1 with `writenum`=0, `vsel`=10, `sximm8`=16'hFFF0 exactly 2 cycles after accept; `w` returns to 1.
- ADD: `in`=16'hA128 (R1 ← R1 + R0<<1). Required sequence:
  - `readnum`=1 with `loada`;
  - `readnum`=0 with `loadb`;
  - `loadc`;
  - `write` with `writenum`=1.
  - 5 cycles total.
- CMP: `in`=16'hA902 → `loads`=1 in ALU, `write` never asserted, back in WAIT after 4 cycles.
- Illegal: `in`=16'hE000 → DECODE then WAIT; no strobe high at any point.
- Reset mid-op: assert `reset` asynchronously during GET_B of an ADD → outputs immediately at reset values; no `write` afterwards.
- Back-to-back: `s` held high across two MOV immediates → two accepts separated by exactly one WAIT cycle; `s` toggling during busy has no effect.
